// File: rtl/spi_arbiter_pkg.sv
// rtl/spi_arbiter_pkg.sv - state encoding, idle status values and grant selection for spi_arbiter
package spi_arbiter_pkg;

  typedef enum logic [3:0] {
    stIdle    = 4'b0000,
    stGrant0  = 4'b0001,
    stGrant1  = 4'b0010,
    stRelease = 4'b0011,
    stGap     = 4'b0100
  } state_t;

  // Status seen by a requester that does not own the SPI master: busy, full, not empty
  localparam logic inactive_transmission = 1'b1;
  localparam logic inactive_fifo_full    = 1'b1;
  localparam logic inactive_fifo_empty   = 1'b0;
  localparam logic inactive_cs_n         = 1'b1;

  localparam int timeout_width = 16;

  // Round-robin between two requesters: on a tie the one not granted last wins
  function automatic state_t pick_grant(logic req0, logic req1, logic last_grant);
    if (req0 && req1) begin
      return last_grant ? stGrant0 : stGrant1;
    end
    if (req0) begin
      return stGrant0;
    end
    if (req1) begin
      return stGrant1;
    end
    return stIdle;
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - requester/SPI master bus bundle; SPI_ARBITER_TIMEOUT_EN adds watchdog ports
interface spi_arbiter_if
  import spi_arbiter_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int GapWidth  = 4
);

  logic                 Req0_i;
  logic                 Req1_i;
  logic                 Grant0_o;
  logic                 Grant1_o;
  logic                 Write0_i;
  logic                 ReadNext0_i;
  logic [DataWidth-1:0] Data0_i;
  logic                 Write1_i;
  logic                 ReadNext1_i;
  logic [DataWidth-1:0] Data1_i;
  logic                 CS0_n_i;
  logic                 CS1_n_i;
  logic                 Dev0_CS_n_o;
  logic                 Dev1_CS_n_o;
  logic                 Transmission0_o;
  logic                 FIFOFull0_o;
  logic                 FIFOEmpty0_o;
  logic                 Transmission1_o;
  logic                 FIFOFull1_o;
  logic                 FIFOEmpty1_o;
  logic                 SPI_Write_o;
  logic                 SPI_ReadNext_o;
  logic [DataWidth-1:0] SPI_Data_o;
  logic                 SPI_Transmission_i;
  logic                 SPI_FIFOFull_i;
  logic                 SPI_FIFOEmpty_i;
  logic [GapWidth-1:0]  ParamGap_i;
`ifdef SPI_ARBITER_TIMEOUT_EN
  logic [timeout_width-1:0] ParamTimeout_i;
  logic                     Timeout_o;
`endif

  modport master (
    input  Req0_i, Req1_i,
    input  Write0_i, ReadNext0_i, Data0_i, CS0_n_i,
    input  Write1_i, ReadNext1_i, Data1_i, CS1_n_i,
    input  SPI_Transmission_i, SPI_FIFOFull_i, SPI_FIFOEmpty_i,
    input  ParamGap_i,
    output Grant0_o, Grant1_o,
    output Dev0_CS_n_o, Dev1_CS_n_o,
    output Transmission0_o, FIFOFull0_o, FIFOEmpty0_o,
    output Transmission1_o, FIFOFull1_o, FIFOEmpty1_o,
    output SPI_Write_o, SPI_ReadNext_o, SPI_Data_o
`ifdef SPI_ARBITER_TIMEOUT_EN
    , input  ParamTimeout_i
    , output Timeout_o
`endif
  );

  modport slave (
    output Req0_i, Req1_i,
    output Write0_i, ReadNext0_i, Data0_i, CS0_n_i,
    output Write1_i, ReadNext1_i, Data1_i, CS1_n_i,
    output SPI_Transmission_i, SPI_FIFOFull_i, SPI_FIFOEmpty_i,
    output ParamGap_i,
    input  Grant0_o, Grant1_o,
    input  Dev0_CS_n_o, Dev1_CS_n_o,
    input  Transmission0_o, FIFOFull0_o, FIFOEmpty0_o,
    input  Transmission1_o, FIFOFull1_o, FIFOEmpty1_o,
    input  SPI_Write_o, SPI_ReadNext_o, SPI_Data_o
`ifdef SPI_ARBITER_TIMEOUT_EN
    , output ParamTimeout_i
    , input  Timeout_o
`endif
  );

endinterface

// File: rtl/spi_arbiter_mux.sv
// rtl/spi_arbiter_mux.sv - combinational routing of controls, status and chip selects by grant
module spi_arbiter_mux
  import spi_arbiter_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic                 grant0,
  input  logic                 grant1,
  input  logic                 write0,
  input  logic                 read_next0,
  input  logic [DataWidth-1:0] data0,
  input  logic                 cs0_n,
  input  logic                 write1,
  input  logic                 read_next1,
  input  logic [DataWidth-1:0] data1,
  input  logic                 cs1_n,
  input  logic                 spi_transmission,
  input  logic                 spi_fifo_full,
  input  logic                 spi_fifo_empty,
  output logic                 spi_write,
  output logic                 spi_read_next,
  output logic [DataWidth-1:0] spi_data,
  output logic                 dev0_cs_n,
  output logic                 dev1_cs_n,
  output logic                 transmission0,
  output logic                 fifo_full0,
  output logic                 fifo_empty0,
  output logic                 transmission1,
  output logic                 fifo_full1,
  output logic                 fifo_empty1
);

  // Without a grant every control toward the SPI master is held at zero
  always_comb begin
    spi_write     = 1'b0;
    spi_read_next = 1'b0;
    spi_data      = '0;
    if (grant0) begin
      spi_write     = write0;
      spi_read_next = read_next0;
      spi_data      = data0;
    end else if (grant1) begin
      spi_write     = write1;
      spi_read_next = read_next1;
      spi_data      = data1;
    end
  end

  assign dev0_cs_n     = grant0 ? cs0_n            : inactive_cs_n;
  assign dev1_cs_n     = grant1 ? cs1_n            : inactive_cs_n;
  assign transmission0 = grant0 ? spi_transmission : inactive_transmission;
  assign fifo_full0    = grant0 ? spi_fifo_full    : inactive_fifo_full;
  assign fifo_empty0   = grant0 ? spi_fifo_empty   : inactive_fifo_empty;
  assign transmission1 = grant1 ? spi_transmission : inactive_transmission;
  assign fifo_full1    = grant1 ? spi_fifo_full    : inactive_fifo_full;
  assign fifo_empty1   = grant1 ? spi_fifo_empty   : inactive_fifo_empty;

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - two-requester SPI master arbiter with post-release gap; SPI_ARBITER_TIMEOUT_EN adds a grant watchdog
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int GapWidth  = 4
) (
  input logic           Clk_i,
  input logic           Reset_n_i,
  spi_arbiter_if.master bus
);

  localparam logic [GapWidth-1:0] gap_one = GapWidth'(1);

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic [GapWidth-1:0] gap_cnt;
  logic [GapWidth-1:0] gap_cnt_nxt;
  logic                grant0;
  logic                grant1;
  logic                req0_eff;
  logic                req1_eff;
  logic                timeout_hit;

  assign grant0 = (state == stGrant0);
  assign grant1 = (state == stGrant1);

`ifdef SPI_ARBITER_TIMEOUT_EN
  logic [timeout_width-1:0] wdog;
  logic                     timeout_q;
  logic [1:0]               blocked;
  logic                     granted;
  logic                     activity;

  assign granted  = grant0 | grant1;
  assign activity = (grant0 & (bus.Write0_i | bus.ReadNext0_i)) |
                    (grant1 & (bus.Write1_i | bus.ReadNext1_i));
  // Fires on the edge where the idle countdown would reach zero
  assign timeout_hit = granted & ~activity & (bus.ParamTimeout_i != '0) &
                       (wdog <= timeout_width'(1));
  assign req0_eff    = bus.Req0_i & ~blocked[0];
  assign req1_eff    = bus.Req1_i & ~blocked[1];
  assign bus.Timeout_o = timeout_q;

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
      blocked   <= 2'b00;
    end else begin
      timeout_q <= timeout_hit;
      // A timed-out requester stays locked out until it withdraws its request
      blocked   <= (blocked & {bus.Req1_i, bus.Req0_i}) | ({2{timeout_hit}} & {grant1, grant0});
      if (!granted && (state_nxt == stGrant0 || state_nxt == stGrant1)) begin
        wdog <= bus.ParamTimeout_i;
      end else if (granted) begin
        if (activity) begin
          wdog <= bus.ParamTimeout_i;
        end else if (wdog != '0) begin
          wdog <= wdog - timeout_width'(1);
        end
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign req0_eff    = bus.Req0_i;
  assign req1_eff    = bus.Req1_i;
`endif

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state      <= stIdle;
      last_grant <= 1'b1;
      gap_cnt    <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      stIdle: begin
        state_nxt = pick_grant(req0_eff, req1_eff, last_grant);
      end
      stGrant0: begin
        if (!bus.Req0_i || timeout_hit) begin
          state_nxt = stRelease;
        end
      end
      stGrant1: begin
        if (!bus.Req1_i || timeout_hit) begin
          state_nxt = stRelease;
        end
      end
      stRelease: begin
        // Hold the bus off until the SPI master finishes its current transfer
        if (!bus.SPI_Transmission_i) begin
          if (bus.ParamGap_i == '0) begin
            state_nxt = stIdle;
          end else begin
            state_nxt   = stGap;
            gap_cnt_nxt = bus.ParamGap_i;
          end
        end
      end
      stGap: begin
        if (gap_cnt <= gap_one) begin
          state_nxt   = stIdle;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt - gap_one;
        end
      end
      default: begin
        state_nxt = stIdle;
      end
    endcase
  end

  assign bus.Grant0_o = grant0;
  assign bus.Grant1_o = grant1;

  spi_arbiter_mux #(
    .DataWidth(DataWidth)
  ) u_mux (
    .grant0           (grant0),
    .grant1           (grant1),
    .write0           (bus.Write0_i),
    .read_next0       (bus.ReadNext0_i),
    .data0            (bus.Data0_i),
    .cs0_n            (bus.CS0_n_i),
    .write1           (bus.Write1_i),
    .read_next1       (bus.ReadNext1_i),
    .data1            (bus.Data1_i),
    .cs1_n            (bus.CS1_n_i),
    .spi_transmission (bus.SPI_Transmission_i),
    .spi_fifo_full    (bus.SPI_FIFOFull_i),
    .spi_fifo_empty   (bus.SPI_FIFOEmpty_i),
    .spi_write        (bus.SPI_Write_o),
    .spi_read_next    (bus.SPI_ReadNext_o),
    .spi_data         (bus.SPI_Data_o),
    .dev0_cs_n        (bus.Dev0_CS_n_o),
    .dev1_cs_n        (bus.Dev1_CS_n_o),
    .transmission0    (bus.Transmission0_o),
    .fifo_full0       (bus.FIFOFull0_o),
    .fifo_empty0      (bus.FIFOEmpty0_o),
    .transmission1    (bus.Transmission1_o),
    .fifo_full1       (bus.FIFOFull1_o),
    .fifo_empty1      (bus.FIFOEmpty1_o)
  );

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - scoreboard bench for spi_arbiter; SPI_ARBITER_TIMEOUT_EN enables the watchdog scenario
`timescale 1ns/1ps
module tb_spi_arbiter;

  localparam int DW = 8;
  localparam int GW = 4;

  typedef struct packed {
    logic          write;
    logic          read_next;
    logic [DW-1:0] data;
    logic          dev0;
    logic          dev1;
    logic          t0;
    logic          ff0;
    logic          fe0;
    logic          t1;
    logic          ff1;
    logic          fe1;
  } route_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     vectors = 0;
  int     miscompares = 0;
  route_t route_q[$];
  int     grant_q[$];

  spi_arbiter_if #(.DataWidth(DW), .GapWidth(GW)) bus ();

  spi_arbiter #(.DataWidth(DW), .GapWidth(GW)) dut (
    .Clk_i     (clk),
    .Reset_n_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.Req0_i = 1'b0;      bus.Req1_i = 1'b0;
    bus.Write0_i = 1'b0;    bus.ReadNext0_i = 1'b0; bus.Data0_i = '0; bus.CS0_n_i = 1'b1;
    bus.Write1_i = 1'b0;    bus.ReadNext1_i = 1'b0; bus.Data1_i = '0; bus.CS1_n_i = 1'b1;
    bus.SPI_Transmission_i = 1'b0; bus.SPI_FIFOFull_i = 1'b0; bus.SPI_FIFOEmpty_i = 1'b1;
    bus.ParamGap_i = '0;
`ifdef SPI_ARBITER_TIMEOUT_EN
    bus.ParamTimeout_i = '0;
`endif
  endtask

  // Expected routing for the requester g owns the bus (g < 0: nobody)
  function automatic route_t model_route(int g);
    route_t r;
    r = '0;
    r.dev0 = 1'b1; r.dev1 = 1'b1;
    r.t0 = 1'b1; r.ff0 = 1'b1; r.fe0 = 1'b0;
    r.t1 = 1'b1; r.ff1 = 1'b1; r.fe1 = 1'b0;
    if (g == 0) begin
      r.write = bus.Write0_i; r.read_next = bus.ReadNext0_i; r.data = bus.Data0_i; r.dev0 = bus.CS0_n_i;
      r.t0 = bus.SPI_Transmission_i; r.ff0 = bus.SPI_FIFOFull_i; r.fe0 = bus.SPI_FIFOEmpty_i;
    end else if (g == 1) begin
      r.write = bus.Write1_i; r.read_next = bus.ReadNext1_i; r.data = bus.Data1_i; r.dev1 = bus.CS1_n_i;
      r.t1 = bus.SPI_Transmission_i; r.ff1 = bus.SPI_FIFOFull_i; r.fe1 = bus.SPI_FIFOEmpty_i;
    end
    return r;
  endfunction

  function automatic route_t dut_route();
    return {bus.SPI_Write_o, bus.SPI_ReadNext_o, bus.SPI_Data_o, bus.Dev0_CS_n_o, bus.Dev1_CS_n_o,
            bus.Transmission0_o, bus.FIFOFull0_o, bus.FIFOEmpty0_o,
            bus.Transmission1_o, bus.FIFOFull1_o, bus.FIFOEmpty1_o};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int budget, output int who, output int cycles);
    who = -1;
    cycles = 0;
    while (who < 0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.Grant0_o) who = 0;
      else if (bus.Grant1_o) who = 1;
    end
  endtask

  task automatic test_reset();
    route_t exp_r;
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    route_q.push_back(model_route(-1));
    vectors++;
    if ({bus.Grant0_o, bus.Grant1_o} !== 2'b00) begin
      miscompares++; $display("FAIL reset_grants got=%b exp=00", {bus.Grant0_o, bus.Grant1_o});
    end
    exp_r = route_q.pop_front();
    vectors++;
    if (dut_route() !== exp_r) begin
      miscompares++; $display("FAIL reset_route got=%h exp=%h", dut_route(), exp_r);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.Grant0_o, bus.Grant1_o} !== 2'b00) begin
      miscompares++; $display("FAIL idle_no_request got=%b exp=00", {bus.Grant0_o, bus.Grant1_o});
    end
  endtask

  task automatic test_single_grant();
    int            who, cycles, exp_g;
    route_t        exp_r;
    logic [DW-1:0] pat_data [4] = '{8'h50, 8'hA5, 8'h00, 8'hFF};
    logic [2:0]    pat_ctl  [4] = '{3'b100, 3'b010, 3'b111, 3'b001};
    do_reset();
    @(negedge clk);
    bus.Req0_i = 1'b1;
    grant_q.push_back(0);
    wait_grant(8, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL single_grant_id got=%0d exp=%0d", who, exp_g);
    end
    vectors++;
    if (cycles !== 1) begin
      miscompares++; $display("FAIL single_grant_latency got=%0d exp=1", cycles);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      bus.Write0_i = pat_ctl[i][2]; bus.ReadNext0_i = pat_ctl[i][1]; bus.CS0_n_i = pat_ctl[i][0];
      bus.Data0_i = pat_data[i];
      bus.Write1_i = 1'b1; bus.Data1_i = 8'h99; bus.CS1_n_i = 1'b0;
      bus.SPI_Transmission_i = i[0]; bus.SPI_FIFOFull_i = i[1]; bus.SPI_FIFOEmpty_i = ~i[0];
      route_q.push_back(model_route(0));
      #1;
      exp_r = route_q.pop_front();
      vectors++;
      if (dut_route() !== exp_r) begin
        miscompares++; $display("FAIL single_route[%0d] got=%h exp=%h", i, dut_route(), exp_r);
      end
    end
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_gap_arbitration();
    int who, cycles, exp_g;
    do_reset();
    @(negedge clk);
    bus.ParamGap_i = 4'd3; bus.Req0_i = 1'b1; bus.Req1_i = 1'b1;
    grant_q.push_back(0);
    grant_q.push_back(1);
    wait_grant(8, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL tie_first_grant got=%0d exp=%0d", who, exp_g);
    end
    @(negedge clk);
    bus.Req0_i = 1'b0;
    wait_grant(40, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL tie_second_grant got=%0d exp=%0d", who, exp_g);
    end
    // release + 3 gap cycles + idle, grant on the next cycle
    vectors++;
    if (cycles !== 3 + 3) begin
      miscompares++; $display("FAIL gap3_latency got=%0d exp=%0d", cycles, 6);
    end
    @(negedge clk);
    drive_idle();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int who, cycles, exp_g, cur;
    int gaps [4] = '{0, 1, 2, 5};
    do_reset();
    @(negedge clk);
    bus.Req0_i = 1'b1; bus.Req1_i = 1'b1;
    grant_q.push_back(0);
    wait_grant(8, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL b2b_first got=%0d exp=%0d", who, exp_g);
    end
    cur = exp_g;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ParamGap_i = GW'(gaps[i]);
      if (cur == 0) bus.Req0_i = 1'b0;
      else bus.Req1_i = 1'b0;
      grant_q.push_back(1 - cur);
      @(negedge clk);
      bus.Req0_i = 1'b1; bus.Req1_i = 1'b1;
      wait_grant(40, who, cycles);
      exp_g = grant_q.pop_front();
      vectors++;
      if (who !== exp_g) begin
        miscompares++; $display("FAIL b2b_grant[%0d] got=%0d exp=%0d", i, who, exp_g);
      end
      vectors++;
      if (cycles !== gaps[i] + 2) begin
        miscompares++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, cycles, gaps[i] + 2);
      end
      cur = exp_g;
    end
    @(negedge clk);
    drive_idle();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_release_hold();
    int     who, cycles, exp_g;
    route_t exp_r;
    do_reset();
    @(negedge clk);
    bus.ParamGap_i = 4'd2; bus.Req0_i = 1'b1;
    grant_q.push_back(0);
    wait_grant(8, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL hold_first_grant got=%0d exp=%0d", who, exp_g);
    end
    @(negedge clk);
    bus.SPI_Transmission_i = 1'b1; bus.Req0_i = 1'b0; bus.Req1_i = 1'b1;
    bus.Write0_i = 1'b1; bus.CS0_n_i = 1'b0; bus.Data0_i = 8'h5A;
    grant_q.push_back(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      route_q.push_back(model_route(-1));
      exp_r = route_q.pop_front();
      vectors++;
      if ({bus.Grant0_o, bus.Grant1_o, dut_route()} !== {2'b00, exp_r}) begin
        miscompares++;
        $display("FAIL hold_release[%0d] got=%b/%h exp=00/%h", i, {bus.Grant0_o, bus.Grant1_o}, dut_route(), exp_r);
      end
    end
    bus.SPI_Transmission_i = 1'b0;
    wait_grant(40, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL hold_next_grant got=%0d exp=%0d", who, exp_g);
    end
    vectors++;
    if (cycles !== 2 + 2) begin
      miscompares++; $display("FAIL hold_gap_latency got=%0d exp=4", cycles);
    end
    @(negedge clk);
    drive_idle();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_isolation();
    int     who, cycles, exp_g;
    route_t exp_r;
    do_reset();
    @(negedge clk);
    bus.Req1_i = 1'b1;
    grant_q.push_back(1);
    wait_grant(8, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL iso_grant got=%0d exp=%0d", who, exp_g);
    end
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      bus.Write0_i = 1'b1; bus.ReadNext0_i = i[0]; bus.CS0_n_i = 1'b0; bus.Data0_i = 8'hFF;
      bus.Write1_i = i[0]; bus.ReadNext1_i = 1'b0; bus.CS1_n_i = i[0]; bus.Data1_i = 8'h3C + 8'(i);
      bus.SPI_Transmission_i = 1'b0; bus.SPI_FIFOFull_i = i[0]; bus.SPI_FIFOEmpty_i = 1'b1;
      route_q.push_back(model_route(1));
      #1;
      exp_r = route_q.pop_front();
      vectors++;
      if (dut_route() !== exp_r) begin
        miscompares++; $display("FAIL iso_route[%0d] got=%h exp=%h", i, dut_route(), exp_r);
      end
    end
    @(negedge clk);
    drive_idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_grant();
    int     who, cycles, exp_g;
    route_t exp_r;
    do_reset();
    @(negedge clk);
    bus.ParamGap_i = 4'd5; bus.Req0_i = 1'b1; bus.Write0_i = 1'b1; bus.Data0_i = 8'h77; bus.CS0_n_i = 1'b0;
    grant_q.push_back(0);
    wait_grant(8, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL midrst_pre_grant got=%0d exp=%0d", who, exp_g);
    end
    #2;
    rst_n = 1'b0;
    bus.Req0_i = 1'b0; bus.Req1_i = 1'b1;
    #1;
    route_q.push_back(model_route(-1));
    exp_r = route_q.pop_front();
    vectors++;
    if ({bus.Grant0_o, bus.Grant1_o, dut_route()} !== {2'b00, exp_r}) begin
      miscompares++;
      $display("FAIL midrst_async got=%b/%h exp=00/%h", {bus.Grant0_o, bus.Grant1_o}, dut_route(), exp_r);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    grant_q.push_back(1);
    wait_grant(8, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL midrst_post_grant got=%0d exp=%0d", who, exp_g);
    end
    vectors++;
    if (cycles !== 1) begin
      miscompares++; $display("FAIL midrst_no_gap got=%0d exp=1", cycles);
    end
    @(negedge clk);
    drive_idle();
    repeat (8) @(negedge clk);
  endtask

`ifdef SPI_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int who, cycles, exp_g, held;
    do_reset();
    @(negedge clk);
    bus.ParamTimeout_i = 16'd10; bus.Req0_i = 1'b1;
    grant_q.push_back(0);
    wait_grant(8, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL wdog_grant got=%0d exp=%0d", who, exp_g);
    end
    held = 1;
    while (bus.Grant0_o && held < 60) begin
      @(negedge clk);
      if (bus.Grant0_o) held++;
    end
    vectors++;
    if (held !== 10) begin
      miscompares++; $display("FAIL wdog_grant_cycles got=%0d exp=10", held);
    end
    vectors++;
    if (bus.Timeout_o !== 1'b1) begin
      miscompares++; $display("FAIL wdog_pulse got=%b exp=1", bus.Timeout_o);
    end
    @(negedge clk);
    vectors++;
    if (bus.Timeout_o !== 1'b0) begin
      miscompares++; $display("FAIL wdog_pulse_width got=%b exp=0", bus.Timeout_o);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if ({bus.Grant0_o, bus.Grant1_o} !== 2'b00) begin
      miscompares++; $display("FAIL wdog_blocked got=%b exp=00", {bus.Grant0_o, bus.Grant1_o});
    end
    bus.Req0_i = 1'b0;
    @(negedge clk);
    bus.Req0_i = 1'b1; bus.ParamTimeout_i = '0;
    grant_q.push_back(0);
    wait_grant(8, who, cycles);
    exp_g = grant_q.pop_front();
    vectors++;
    if (who !== exp_g) begin
      miscompares++; $display("FAIL wdog_regrant got=%0d exp=%0d", who, exp_g);
    end
    repeat (30) @(negedge clk);
    vectors++;
    if ({bus.Grant0_o, bus.Timeout_o} !== 2'b10) begin
      miscompares++; $display("FAIL wdog_disabled got=%b exp=10", {bus.Grant0_o, bus.Timeout_o});
    end
    @(negedge clk);
    drive_idle();
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    drive_idle();
    test_reset();
    test_single_grant();
    test_gap_arbitration();
    test_back_to_back();
    test_release_hold();
    test_isolation();
    test_reset_mid_grant();
`ifdef SPI_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    vectors++;
    if (grant_q.size() + route_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain got=%0d exp=0", grant_q.size() + route_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
